alu_input_ctrl: RTL

//  Front-end stage feeding the ALU top level. Synchronises and debounces the

---
 rtl/alu_input_ctrl.sv | 80 ++++++++
 1 files changed

// File: rtl/alu_input_ctrl.sv
// ALU front end: synchronises and debounces three push-buttons, turns each debounced
// press into a one-cycle load strobe and captures the switch bank into A, B or the opcode.
module alu_input_ctrl #(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int DBNC_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [2:0]         i_btn,
  input  logic [NB_DATA-1:0] i_sw_data,
  input  logic [NB_OP-1:0]   i_sw_op,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [2:0]         o_load,
  output logic [2:0]         o_btn_db
);

  localparam int NB_CNT = $clog2(DBNC_CYCLES);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DBNC_CYCLES - 1);

  logic [2:0]        sync_1;
  logic [2:0]        sync_2;
  logic [2:0]        btn_db_prev;
  logic [NB_CNT-1:0] dbnc_cnt [3];
  logic [2:0]        press;
  logic [2:0]        load_sel;

  // A level is accepted only after DBNC_CYCLES consecutive samples disagree with the
  // current debounced level; any sample that agrees restarts the count.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_1      <= '0;
      sync_2      <= '0;
      o_btn_db    <= '0;
      btn_db_prev <= '0;
      for (int i = 0; i < 3; i++) dbnc_cnt[i] <= '0;
    end else begin
      sync_1      <= i_btn;
      sync_2      <= sync_1;
      btn_db_prev <= o_btn_db;
      for (int i = 0; i < 3; i++) begin
        if (sync_2[i] == o_btn_db[i]) begin
          dbnc_cnt[i] <= '0;
        end else if (dbnc_cnt[i] == CNT_LAST) begin
          o_btn_db[i] <= sync_2[i];
          dbnc_cnt[i] <= '0;
        end else begin
          dbnc_cnt[i] <= dbnc_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = o_btn_db & ~btn_db_prev;

  // Coincident presses are resolved A > B > OP; the losers are dropped, not queued.
  always_comb begin
    load_sel = 3'b000;
    if (press[0])      load_sel = 3'b001;
    else if (press[1]) load_sel = 3'b010;
    else if (press[2]) load_sel = 3'b100;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data_a <= '0;
      o_data_b <= '0;
      o_op     <= '0;
      o_load   <= '0;
    end else begin
      o_load <= load_sel;
      if (load_sel[0]) o_data_a <= i_sw_data;
      if (load_sel[1]) o_data_b <= i_sw_data;
      if (load_sel[2]) o_op     <= i_sw_op;
    end
  end

endmodule
